// File: rtl/gcd_req_arbiter_if.sv
// Requester-side and GCD-unit-side signals of gcd_req_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the clients and the unit.
interface gcd_req_arbiter_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N-1:0]         req_val;
  logic [N-1:0]         req_rdy;
  logic [N-1:0][W-1:0]  req_a;
  logic [N-1:0][W-1:0]  req_b;
  logic [N-1:0]         resp_val;
  logic [N-1:0]         resp_rdy;
  logic [W-1:0]         resp_data;
  logic [W-1:0]         gcd_operand_A;
  logic [W-1:0]         gcd_operand_B;
  logic                 gcd_input_available;
  logic                 gcd_result_taken;
  logic [W-1:0]         gcd_result_data;
  logic                 gcd_result_rdy;

  modport slave (
    input  req_val, req_a, req_b, resp_rdy, gcd_result_data, gcd_result_rdy,
    output req_rdy, resp_val, resp_data, gcd_operand_A, gcd_operand_B,
           gcd_input_available, gcd_result_taken
  );

  modport master (
    output req_val, req_a, req_b, resp_rdy, gcd_result_data, gcd_result_rdy,
    input  req_rdy, resp_val, resp_data, gcd_operand_A, gcd_operand_B,
           gcd_input_available, gcd_result_taken
  );
endinterface

// File: rtl/gcd_req_arbiter.sv
// Round-robin front end sharing one GCD unit among N requesters, with one transaction in flight.
// GCD_ARB_ZERO_BYPASS_EN: pairs with a zero operand are answered directly, without using the unit.
module gcd_req_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  gcd_req_arbiter_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d;
  logic [IW-1:0] sel;
  logic          found;

  // The scan starts at last+1 and wraps, so the requester served most recently has the lowest priority.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_q) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && bus.req_val[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  always_comb begin
    state_d                 = state_q;
    op_a_d                  = op_a_q;
    op_b_d                  = op_b_q;
    res_d                   = res_q;
    grant_d                 = grant_q;
    last_d                  = last_q;
    bus.req_rdy             = '0;
    bus.resp_val            = '0;
    bus.gcd_input_available = 1'b0;
    bus.gcd_result_taken    = 1'b0;
    case (state_q)
      S_IDLE: if (found) begin
        bus.req_rdy[sel] = 1'b1;
        op_a_d           = bus.req_a[sel];
        op_b_d           = bus.req_b[sel];
        grant_d          = sel;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        if (bus.req_a[sel] == '0 || bus.req_b[sel] == '0) begin
          res_d   = bus.req_a[sel] | bus.req_b[sel];
          state_d = S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
`else
        state_d = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        bus.gcd_input_available = 1'b1;
        state_d                 = S_BUSY;
      end
      S_BUSY: if (bus.gcd_result_rdy) begin
        bus.gcd_result_taken = 1'b1;
        res_d                = bus.gcd_result_data;
        state_d              = S_RESP;
      end
      default: begin
        bus.resp_val[grant_q] = 1'b1;
        if (bus.resp_rdy[grant_q]) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.gcd_operand_A = op_a_q;
  assign bus.gcd_operand_B = op_b_q;
  assign bus.resp_data     = res_q;
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter. The bench includes a subtractive GCD unit model that
// follows the WAIT / compute / result-ready-until-taken handshake.
module tb_gcd_req_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int LIM = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ia_cnt  = 0;
  int   tk_cnt  = 0;
  int   ia0, tk0;

  always #5 clk = ~clk;

  gcd_req_arbiter_if #(.N(N), .W(W)) bus ();

  gcd_req_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // GCD unit model: 0 = WAIT, 1 = compute, 2 = result ready until taken
  logic [1:0]   mst;
  logic [W-1:0] ma, mb, mres;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst <= 2'd0; ma <= '0; mb <= '0; mres <= '0;
    end else begin
      case (mst)
        2'd0: if (bus.gcd_input_available) begin
          ma <= bus.gcd_operand_A; mb <= bus.gcd_operand_B; mst <= 2'd1;
        end
        2'd1: begin
          if (ma == '0) begin mres <= mb; mst <= 2'd2; end
          else if (mb == '0 || ma == mb) begin mres <= ma; mst <= 2'd2; end
          else if (ma > mb) ma <= ma - mb;
          else mb <= mb - ma;
        end
        default: if (bus.gcd_result_taken) mst <= 2'd0;
      endcase
    end
  end
  assign bus.gcd_result_rdy  = (mst == 2'd2);
  assign bus.gcd_result_data = mres;

  always @(posedge clk) begin
    if (bus.gcd_input_available) ia_cnt <= ia_cnt + 1;
    if (bus.gcd_result_taken)    tk_cnt <= tk_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // which: 0 waits for any req_rdy, 1 waits for any resp_val
  task automatic wait_nz(input string tag, input int which);
    int c;
    c = 0;
    while (c < LIM && ((which == 0) ? bus.req_rdy : bus.resp_val) == '0) begin
      step();
      c++;
    end
    if (c >= LIM) check({tag, "_timeout"}, 32'(c), 32'(0));
  endtask

  task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_val[i] = 1'b1;
    bus.req_a[i]   = a;
    bus.req_b[i]   = b;
  endtask

  // Pending requests are already driven. Expect grant g, then result exp, with resp_rdy high.
  task automatic serve(input int g, input logic [W-1:0] exp, input string tag);
    wait_nz({tag, "_rdy"}, 0);
    check({tag, "_grant"}, 32'(bus.req_rdy), 32'(1) << g);
    @(posedge clk);
    step();
    bus.req_val[g] = 1'b0;
    wait_nz({tag, "_resp"}, 1);
    check({tag, "_resp_val"}, 32'(bus.resp_val), 32'(1) << g);
    check({tag, "_data"}, 32'(bus.resp_data), 32'(exp));
    @(posedge clk);
    step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_val  = '0;
    bus.req_a    = '0;
    bus.req_b    = '0;
    bus.resp_rdy = '1;
    repeat (2) step();
    // reset state
    check("rst_req_rdy", 32'(bus.req_rdy), 0);
    check("rst_resp_val", 32'(bus.resp_val), 0);
    check("rst_ia", 32'(bus.gcd_input_available), 0);
    check("rst_taken", 32'(bus.gcd_result_taken), 0);
    check("rst_data", 32'(bus.resp_data), 0);
    check("rst_opA", 32'(bus.gcd_operand_A), 0);
    rst_n = 1'b1;

    // single request 27/15
    step();
    drive(0, 16'd27, 16'd15);
    #1;
    wait_nz("single_rdy", 0);
    check("single_grant", 32'(bus.req_rdy), 32'h1);
    ia0 = ia_cnt; tk0 = tk_cnt;
    @(posedge clk);
    step();
    bus.req_val[0] = 1'b0;
    check("single_ia_t1", 32'(bus.gcd_input_available), 1);
    check("single_opA", 32'(bus.gcd_operand_A), 27);
    check("single_opB", 32'(bus.gcd_operand_B), 15);
    step();
    check("single_ia_t2", 32'(bus.gcd_input_available), 0);
    wait_nz("single_resp", 1);
    check("single_resp_val", 32'(bus.resp_val), 32'h1);
    check("single_data", 32'(bus.resp_data), 3);
    @(posedge clk);
    step();
    check("single_ia_cnt", 32'(ia_cnt - ia0), 1);
    check("single_tk_cnt", 32'(tk_cnt - tk0), 1);
    check("single_resp_clr", 32'(bus.resp_val), 0);

    // round-robin from reset
    do_reset();
    step();
    drive(0, 16'd12, 16'd8);
    drive(1, 16'd9, 16'd6);
    drive(2, 16'd35, 16'd14);
    drive(3, 16'd17, 16'd5);
    #1;
    serve(0, 16'd4, "rr0");
    serve(1, 16'd3, "rr1");
    serve(2, 16'd7, "rr2");
    serve(3, 16'd1, "rr3");
    drive(0, 16'd100, 16'd75);
    drive(2, 16'd21, 16'd14);
    #1;
    serve(0, 16'd25, "rr2_0");
    serve(2, 16'd7, "rr2_2");

    // response backpressure on requester 1; other resp_rdy bits are high
    bus.resp_rdy = 4'b1101;
    drive(1, 16'd9, 16'd6);
    #1;
    wait_nz("bp_rdy", 0);
    check("bp_grant", 32'(bus.req_rdy), 32'h2);
    @(posedge clk);
    step();
    bus.req_val[1] = 1'b0;
    wait_nz("bp_resp", 1);
    drive(0, 16'd0, 16'd21);
    ia0 = ia_cnt;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_resp_val", 32'(bus.resp_val), 32'h2);
      check("bp_data", 32'(bus.resp_data), 3);
      check("bp_no_rdy", 32'(bus.req_rdy), 0);
    end
    check("bp_no_ia", 32'(ia_cnt - ia0), 0);
    bus.resp_rdy = '1;
    @(posedge clk);
    step();

    // zero operand 0/21 from requester 0, pending since RESP
    wait_nz("zero_rdy", 0);
    check("zero_grant", 32'(bus.req_rdy), 32'h1);
    ia0 = ia_cnt;
    @(posedge clk);
    step();
    bus.req_val[0] = 1'b0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
    check("zero_resp_t1", 32'(bus.resp_val), 32'h1);
    check("zero_no_ia", 32'(bus.gcd_input_available), 0);
`else
    check("zero_ia_t1", 32'(bus.gcd_input_available), 1);
`endif
    wait_nz("zero_resp", 1);
    check("zero_data", 32'(bus.resp_data), 21);
    @(posedge clk);
    step();
`ifdef GCD_ARB_ZERO_BYPASS_EN
    check("zero_ia_cnt", 32'(ia_cnt - ia0), 0);
`else
    check("zero_ia_cnt", 32'(ia_cnt - ia0), 1);
`endif

    // reset while BUSY
    drive(2, 16'd50, 16'd20);
    #1;
    wait_nz("rb_rdy", 0);
    check("rb_grant", 32'(bus.req_rdy), 32'h4);
    @(posedge clk);
    step();
    bus.req_val[2] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rb_resp_val", 32'(bus.resp_val), 0);
    check("rb_ia", 32'(bus.gcd_input_available), 0);
    check("rb_data", 32'(bus.resp_data), 0);
    check("rb_opA", 32'(bus.gcd_operand_A), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rb_no_stale", 32'(bus.resp_val), 0);
    drive(0, 16'd48, 16'd18);
    drive(3, 16'd14, 16'd21);
    #1;
    serve(0, 16'd6, "rb_r0");
    serve(3, 16'd7, "rb_r3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
